// File: rtl/nco_multi.sv
// nco_multi: time-multiplexed multi-channel numerically controlled oscillator.
//
// A single phase-accumulator datapath and a single quarter-wave sine ROM are
// shared among CHANNELS oscillators. Each oscillator owns one slot per
// rotation. Signed sin/cos pairs come out of a 3-stage pipeline, tagged with
// the channel number.
//
// Ports:
//   CLK        clock
//   RSTb       synchronous, active-low reset
//   cfg_wr     one-cycle config write strobe, always accepted
//   cfg_ch     target channel of the write; values >= CHANNELS are ignored
//   cfg_inc    new phase increment
//   cfg_clr    with cfg_wr, also clear the channel's phase when applied
//   out_valid  sample-valid strobe
//   out_ch     channel tag of the current sample
//   sin, cos   signed output samples
//
// Optional build macro: NCO_MULTI_DITHER_EN. When it is defined, a 32-bit LFSR
// dithers the lookup phase before truncation. The dither assumes
// PHASE_INC_BITS-LUT_BITS <= 32.
module nco_multi #(
  parameter int PHASE_INC_BITS = 40,
  parameter int BITS           = 16,
  parameter int LUT_BITS       = 10,
  parameter int CHANNELS       = 4,
  localparam int CH_BITS       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      CLK,
  input  logic                      RSTb,
  input  logic                      cfg_wr,
  input  logic [CH_BITS-1:0]        cfg_ch,
  input  logic [PHASE_INC_BITS-1:0] cfg_inc,
  input  logic                      cfg_clr,
  output logic                      out_valid,
  output logic [CH_BITS-1:0]        out_ch,
  output logic signed [BITS-1:0]    sin,
  output logic signed [BITS-1:0]    cos
);

  localparam int ADDR_BITS = LUT_BITS - 2;
  localparam int ROM_DEPTH = 1 << ADDR_BITS;

  // Quarter-wave entry, sampled at the middle of each step so that no entry
  // is exactly zero.
  function automatic logic [BITS-2:0] rom_val(input int idx);
    real amp;
    real ang;
    int  v;
    amp = real'((32'sd1 <<< (BITS - 1)) - 32'sd1);
    ang = 3.14159265358979 / 2.0 * (real'(idx) + 0.5) / real'(ROM_DEPTH);
    v   = $rtoi(amp * $sin(ang) + 0.5);
    return v[BITS-2:0];
  endfunction

  logic [BITS-2:0] rom [ROM_DEPTH];

  for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_rom
    assign rom[i] = rom_val(i);
  end

  // Per-channel state
  logic [PHASE_INC_BITS-1:0] phase  [CHANNELS];
  logic [PHASE_INC_BITS-1:0] inc    [CHANNELS];
  logic [PHASE_INC_BITS-1:0] sh_inc [CHANNELS];
  logic [CHANNELS-1:0]       sh_clr;
  logic [CHANNELS-1:0]       pend;
  logic [CH_BITS-1:0]        slot;

  // Pipeline registers
  logic                 s1_valid, s2_valid;
  logic [CH_BITS-1:0]   s1_ch, s2_ch;
  logic                 s1_sin_neg, s1_cos_neg, s2_sin_neg, s2_cos_neg;
  logic [ADDR_BITS-1:0] s1_sin_a, s1_cos_a;
  logic [BITS-2:0]      s2_sin_mag, s2_cos_mag;

  // Lookup phase of the channel that owns the current slot
  logic [LUT_BITS-1:0]  p_sin, p_cos;

`ifdef NCO_MULTI_DITHER_EN
  localparam int DW = PHASE_INC_BITS - LUT_BITS;
  logic [31:0]               lfsr;
  logic [PHASE_INC_BITS-1:0] dith_phase;

  // Fibonacci LFSR with taps 32,22,2,1, free-running
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      lfsr <= 32'hACE1ACE1;
    end else begin
      lfsr <= {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
    end
  end

  // Dither only affects the lookup; the accumulator itself is untouched
  always_comb begin
    dith_phase = phase[slot] + PHASE_INC_BITS'(lfsr[DW-1:0]);
    p_sin      = dith_phase[PHASE_INC_BITS-1 -: LUT_BITS];
  end
`else
  // Plain truncation of the pre-update phase
  always_comb begin
    p_sin = phase[slot][PHASE_INC_BITS-1 -: LUT_BITS];
  end
`endif

  // Cosine is sine advanced by a quarter turn
  always_comb begin
    p_cos = p_sin + {2'b01, {ADDR_BITS{1'b0}}};
  end

  // Slot rotation, accumulator update and config shadow handling
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      slot   <= '0;
      sh_clr <= '0;
      pend   <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        phase[k]  <= '0;
        inc[k]    <= '0;
        sh_inc[k] <= '0;
      end
    end else begin
      slot <= (slot == CH_BITS'(CHANNELS - 1)) ? '0 : slot + CH_BITS'(1);
      for (int k = 0; k < CHANNELS; k++) begin
        if (slot == CH_BITS'(k)) begin
          if (pend[k]) begin
            inc[k]   <= sh_inc[k];
            phase[k] <= sh_clr[k] ? '0 : phase[k] + inc[k];
          end else begin
            phase[k] <= phase[k] + inc[k];
          end
        end
        // A write in the channel's own slot survives that slot's consumption,
        // so it waits a full rotation. The clr bit is ORed only with a
        // pending write that has not been consumed.
        if (cfg_wr && (cfg_ch == CH_BITS'(k))) begin
          sh_inc[k] <= cfg_inc;
          pend[k]   <= 1'b1;
          sh_clr[k] <= cfg_clr | (pend[k] & sh_clr[k] & (slot != CH_BITS'(k)));
        end else if (slot == CH_BITS'(k)) begin
          pend[k] <= 1'b0;
        end
      end
    end
  end

  // Stage 1: quadrant decode and ROM address mirroring
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      s1_valid   <= 1'b0;
      s1_ch      <= '0;
      s1_sin_neg <= 1'b0;
      s1_cos_neg <= 1'b0;
      s1_sin_a   <= '0;
      s1_cos_a   <= '0;
    end else begin
      s1_valid   <= 1'b1;
      s1_ch      <= slot;
      s1_sin_neg <= p_sin[LUT_BITS-1];
      s1_cos_neg <= p_cos[LUT_BITS-1];
      s1_sin_a   <= p_sin[ADDR_BITS-1:0] ^ {ADDR_BITS{p_sin[LUT_BITS-2]}};
      s1_cos_a   <= p_cos[ADDR_BITS-1:0] ^ {ADDR_BITS{p_cos[LUT_BITS-2]}};
    end
  end

  // Stage 2: ROM read
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      s2_valid   <= 1'b0;
      s2_ch      <= '0;
      s2_sin_neg <= 1'b0;
      s2_cos_neg <= 1'b0;
      s2_sin_mag <= '0;
      s2_cos_mag <= '0;
    end else begin
      s2_valid   <= s1_valid;
      s2_ch      <= s1_ch;
      s2_sin_neg <= s1_sin_neg;
      s2_cos_neg <= s1_cos_neg;
      s2_sin_mag <= rom[s1_sin_a];
      s2_cos_mag <= rom[s1_cos_a];
    end
  end

  // Stage 3: sign application; outputs hold while no sample is valid
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      sin       <= '0;
      cos       <= '0;
    end else begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_ch <= s2_ch;
        sin    <= s2_sin_neg ? -$signed({1'b0, s2_sin_mag}) : $signed({1'b0, s2_sin_mag});
        cos    <= s2_cos_neg ? -$signed({1'b0, s2_cos_mag}) : $signed({1'b0, s2_cos_mag});
      end else begin
        out_ch <= out_ch;
        sin    <= sin;
        cos    <= cos;
      end
    end
  end

endmodule
